// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions: default widths, ICC width and a round-robin index helper.
// ICC bit order on every flags bus is {c,v,z,n}, so c is bit 3 and n is bit 0.
package cdb_arbiter_pkg;

    localparam int DEF_TAG_W  = 5;
    localparam int DEF_DATA_W = 32;
    localparam int ICC_W      = 4;

    function automatic int next_idx(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: the first set req bit at or after ptr wins.
// The grant is one-hot, or zero when no bit is set.
module rr_select #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic             any
);

    always_comb begin
        grant = '0;
        any   = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!any && req[(int'(ptr) + k) % N]) begin
                grant[(int'(ptr) + k) % N] = 1'b1;
                any                        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Serialises reservation-station results onto the Common Data Bus through one-entry
// capture buffers and a round-robin picker, with a registered one-cycle broadcast.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int TAG_W   = DEF_TAG_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC-1:0]        in_valid,
    input  logic [NUM_SRC*TAG_W-1:0]  in_tag,
    input  logic [NUM_SRC*DATA_W-1:0] in_val,
    input  logic [NUM_SRC*ICC_W-1:0]  in_icc,
    input  logic [NUM_SRC-1:0]        in_icc_we,
    output logic [NUM_SRC-1:0]        out_ready,
    output logic                      out_CDB_broadcast,
    output logic [TAG_W-1:0]          out_CDB_tag,
    output logic [DATA_W-1:0]         out_CDB_val,
    output logic [ICC_W-1:0]          out_ICC_flags,
    output logic                      out_ICC_we,
    output logic                      out_tag_err
);

    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [TAG_W-1:0] INVALID_TAG = '1;

    // Handshake: source i transfers at a rising edge when in_valid[i] && out_ready[i];
    // out_ready depends only on buffer state and the current grant, never on in_valid.
    logic [NUM_SRC-1:0] r_full;
    logic [TAG_W-1:0]   r_tag    [NUM_SRC];
    logic [DATA_W-1:0]  r_val    [NUM_SRC];
    logic [ICC_W-1:0]   r_icc    [NUM_SRC];
    logic [NUM_SRC-1:0] r_icc_we;
    logic [PTR_W-1:0]   r_ptr;

    logic               r_bc;
    logic [TAG_W-1:0]   r_out_tag;
    logic [DATA_W-1:0]  r_out_val;
    logic [ICC_W-1:0]   r_out_icc;
    logic               r_out_we;
    logic               r_tag_err;

    logic [NUM_SRC-1:0] w_sel;
    logic               w_any;
    logic [NUM_SRC-1:0] w_take;
    logic [NUM_SRC-1:0] w_bad;
    logic [PTR_W-1:0]   w_win_idx;
    logic [TAG_W-1:0]   w_win_tag;
    logic [DATA_W-1:0]  w_win_val;
    logic [ICC_W-1:0]   w_win_icc;
    logic               w_win_we;

    rr_select #(.N(NUM_SRC), .PTR_W(PTR_W)) u_rr_select (
        .req   (r_full),
        .ptr   (r_ptr),
        .grant (w_sel),
        .any   (w_any)
    );

    assign out_ready = ~r_full | w_sel;
    assign w_take    = in_valid & out_ready;

    always_comb begin
        w_bad     = '0;
        w_win_idx = '0;
        w_win_tag = '0;
        w_win_val = '0;
        w_win_icc = '0;
        w_win_we  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_bad[i] = (in_tag[i*TAG_W +: TAG_W] == INVALID_TAG);
            if (w_sel[i]) begin
                w_win_idx = PTR_W'(i);
                w_win_tag = r_tag[i];
                w_win_val = r_val[i];
                w_win_icc = r_icc[i];
                w_win_we  = r_icc_we[i];
            end
        end
    end

    // A refill at the drain edge wins over the clear, so full stays set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full   <= '0;
            r_icc_we <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                r_tag[i] <= '0;
                r_val[i] <= '0;
                r_icc[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (w_take[i] && !w_bad[i]) begin
                    r_full[i]   <= 1'b1;
                    r_tag[i]    <= in_tag[i*TAG_W +: TAG_W];
                    r_val[i]    <= in_val[i*DATA_W +: DATA_W];
                    r_icc[i]    <= in_icc[i*ICC_W +: ICC_W];
                    r_icc_we[i] <= in_icc_we[i];
                end else if (w_sel[i]) begin
                    r_full[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr     <= '0;
            r_bc      <= 1'b0;
            r_out_tag <= '0;
            r_out_val <= '0;
            r_out_icc <= '0;
            r_out_we  <= 1'b0;
            r_tag_err <= 1'b0;
        end else begin
            r_bc     <= w_any;
            r_out_we <= w_any & w_win_we;
            if (w_any) begin
                r_ptr     <= PTR_W'(next_idx(int'(w_win_idx), NUM_SRC));
                r_out_tag <= w_win_tag;
                r_out_val <= w_win_val;
                r_out_icc <= w_win_icc;
            end
            if (|(w_take & w_bad)) begin
                r_tag_err <= 1'b1;
            end
        end
    end

    assign out_CDB_broadcast = r_bc;
    assign out_CDB_tag       = r_out_tag;
    assign out_CDB_val       = r_out_val;
    assign out_ICC_flags     = r_out_icc;
    assign out_ICC_we        = r_out_we;
    assign out_tag_err       = r_tag_err;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus random traffic, each cycle checked
// against a buffer-array reference model of the arbitration rules.
module tb_cdb_arbiter;

    localparam int NUM = 4;
    localparam int TW  = 5;
    localparam int DW  = 32;
    localparam int INV = 31;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [NUM-1:0]    d_valid;
    logic [NUM-1:0]    d_we;
    logic [TW-1:0]     d_tag [NUM];
    logic [DW-1:0]     d_val [NUM];
    logic [3:0]        d_icc [NUM];

    logic [NUM-1:0]    in_valid;
    logic [NUM*TW-1:0] in_tag;
    logic [NUM*DW-1:0] in_val;
    logic [NUM*4-1:0]  in_icc;
    logic [NUM-1:0]    in_icc_we;

    logic [NUM-1:0]    out_ready;
    logic              out_CDB_broadcast;
    logic [TW-1:0]     out_CDB_tag;
    logic [DW-1:0]     out_CDB_val;
    logic [3:0]        out_ICC_flags;
    logic              out_ICC_we;
    logic              out_tag_err;

    always_comb begin
        in_valid  = d_valid;
        in_icc_we = d_we;
        in_tag    = '0;
        in_val    = '0;
        in_icc    = '0;
        for (int i = 0; i < NUM; i++) begin
            in_tag[i*TW +: TW] = d_tag[i];
            in_val[i*DW +: DW] = d_val[i];
            in_icc[i*4 +: 4]   = d_icc[i];
        end
    end

    cdb_arbiter #(.NUM_SRC(NUM), .TAG_W(TW), .DATA_W(DW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_valid          (in_valid),
        .in_tag            (in_tag),
        .in_val            (in_val),
        .in_icc            (in_icc),
        .in_icc_we         (in_icc_we),
        .out_ready         (out_ready),
        .out_CDB_broadcast (out_CDB_broadcast),
        .out_CDB_tag       (out_CDB_tag),
        .out_CDB_val       (out_CDB_val),
        .out_ICC_flags     (out_ICC_flags),
        .out_ICC_we        (out_ICC_we),
        .out_tag_err       (out_tag_err)
    );

    // Clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Reference model: one slot per source, a search pointer, and the broadcast registers.
    bit          m_full [NUM];
    logic [TW-1:0] m_tag [NUM];
    logic [DW-1:0] m_val [NUM];
    logic [3:0]  m_icc [NUM];
    bit          m_we  [NUM];
    int          m_ptr;
    bit          m_bc, m_owe, m_err;
    logic [TW-1:0] m_otag;
    logic [DW-1:0] m_oval;
    logic [3:0]  m_oicc;

    logic [TW-1:0] obs_q [$];
    int            obs_cyc [$];

    task automatic clear_drive();
        d_valid = '0;
        d_we    = '0;
        for (int i = 0; i < NUM; i++) begin
            d_tag[i] = '0;
            d_val[i] = '0;
            d_icc[i] = '0;
        end
    endtask

    task automatic drive(input int src, input int tag, input logic [DW-1:0] val,
                         input logic [3:0] icc, input bit we);
        d_valid[src] = 1'b1;
        d_tag[src]   = TW'(tag);
        d_val[src]   = val;
        d_icc[src]   = icc;
        d_we[src]    = we;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM; i++) begin
            m_full[i] = 0;
            m_tag[i]  = '0;
            m_val[i]  = '0;
            m_icc[i]  = '0;
            m_we[i]   = 0;
        end
        m_ptr = 0; m_bc = 0; m_owe = 0; m_err = 0;
        m_otag = '0; m_oval = '0; m_oicc = '0;
    endtask

    // Driver + model step: check ready, advance model, take one edge, check outputs.
    task automatic tick();
        int win;
        logic [NUM-1:0] exp_ready;
        win = -1;
        for (int k = 0; k < NUM; k++) begin
            int j;
            j = (m_ptr + k) % NUM;
            if (win < 0 && m_full[j]) win = j;
        end
        for (int i = 0; i < NUM; i++) exp_ready[i] = !m_full[i] || (i == win);
        n_checks++;
        if (out_ready !== exp_ready) begin
            n_errors++;
            $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, out_ready, exp_ready);
        end
        if (win >= 0) begin
            m_bc = 1; m_otag = m_tag[win]; m_oval = m_val[win];
            m_oicc = m_icc[win]; m_owe = m_we[win];
            m_full[win] = 0;
            m_ptr = (win + 1) % NUM;
        end else begin
            m_bc = 0; m_owe = 0;
        end
        for (int i = 0; i < NUM; i++) begin
            if (d_valid[i] && exp_ready[i]) begin
                if (int'(d_tag[i]) == INV) m_err = 1;
                else begin
                    m_full[i] = 1; m_tag[i] = d_tag[i]; m_val[i] = d_val[i];
                    m_icc[i] = d_icc[i]; m_we[i] = d_we[i];
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        n_checks++;
        if (out_CDB_broadcast !== m_bc || out_CDB_tag !== m_otag || out_CDB_val !== m_oval ||
            out_ICC_flags !== m_oicc || out_ICC_we !== m_owe || out_tag_err !== m_err) begin
            n_errors++;
            $display("FAIL outputs cyc=%0d got bc=%b tag=%0d val=%h icc=%b we=%b err=%b exp bc=%b tag=%0d val=%h icc=%b we=%b err=%b",
                     cyc, out_CDB_broadcast, out_CDB_tag, out_CDB_val, out_ICC_flags, out_ICC_we,
                     out_tag_err, m_bc, m_otag, m_oval, m_oicc, m_owe, m_err);
        end
        if (out_CDB_broadcast === 1'b1) begin
            obs_q.push_back(out_CDB_tag);
            obs_cyc.push_back(cyc);
        end
    endtask

    task automatic idle(input int n);
        clear_drive();
        for (int k = 0; k < n; k++) tick();
    endtask

    // Called just after a rising edge; reset pulse ends before the next edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        model_reset();
        clear_drive();
        obs_q.delete();
        obs_cyc.delete();
        #2;
    endtask

    task automatic test_reset();
        clear_drive();
        model_reset();
        rst_n = 1'b0;
        #12;
        n_checks++;
        if (out_CDB_broadcast !== 0 || out_CDB_tag !== 0 || out_CDB_val !== 0 ||
            out_ICC_flags !== 0 || out_ICC_we !== 0 || out_tag_err !== 0 || out_ready !== 4'b1111) begin
            n_errors++;
            $display("FAIL reset_state got bc=%b tag=%0d val=%h icc=%b we=%b err=%b ready=%b exp all zero, ready=1111",
                     out_CDB_broadcast, out_CDB_tag, out_CDB_val, out_ICC_flags, out_ICC_we, out_tag_err, out_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        do_reset();
        drive(0, 5, 32'h0000_0007, 4'b0000, 0);
        tick();
        clear_drive();
        tick();
        n_checks++;
        if (out_CDB_broadcast !== 1 || out_CDB_tag !== 5 || out_CDB_val !== 32'h7 || out_ICC_we !== 0) begin
            n_errors++;
            $display("FAIL single got bc=%b tag=%0d val=%h we=%b exp bc=1 tag=5 val=7 we=0",
                     out_CDB_broadcast, out_CDB_tag, out_CDB_val, out_ICC_we);
        end
        tick();
        n_checks++;
        if (out_CDB_broadcast !== 0) begin
            n_errors++;
            $display("FAIL single_strobe_len got bc=%b exp 0", out_CDB_broadcast);
        end
    endtask

    task automatic test_three_way();
        do_reset();
        for (int s = 0; s < 3; s++) drive(s, 20 + s, $urandom, 4'($urandom), 1'($urandom));
        tick();
        idle(4);
        n_checks++;
        if (obs_q.size() != 3 || obs_q[0] !== 20 || obs_q[1] !== 21 || obs_q[2] !== 22 ||
            obs_cyc[1] != obs_cyc[0] + 1 || obs_cyc[2] != obs_cyc[1] + 1) begin
            n_errors++;
            $display("FAIL three_way got n=%0d order=%p exp 3 consecutive 20,21,22", obs_q.size(), obs_q);
        end
        // Pointer now sits at 3, so source 3 must win over source 0.
        obs_q.delete();
        obs_cyc.delete();
        drive(0, 8, $urandom, 4'b0, 0);
        drive(3, 11, $urandom, 4'b0, 0);
        tick();
        idle(3);
        n_checks++;
        if (obs_q.size() != 2 || obs_q[0] !== 11 || obs_q[1] !== 8) begin
            n_errors++;
            $display("FAIL ptr_after_tie got order=%p exp 11,8", obs_q);
        end
    endtask

    task automatic test_fairness();
        int alt_bad;
        do_reset();
        for (int t = 0; t < 20; t++) begin
            clear_drive();
            drive(0, 10, $urandom, 4'($urandom), 1'($urandom));
            drive(3, 13, $urandom, 4'($urandom), 1'($urandom));
            tick();
        end
        idle(3);
        alt_bad = 0;
        for (int k = 1; k < obs_q.size(); k++) begin
            if (obs_q[k] === obs_q[k-1] || obs_cyc[k] != obs_cyc[k-1] + 1) alt_bad++;
        end
        n_checks++;
        if (obs_q.size() != 21 || obs_q[0] !== 10 || alt_bad != 0) begin
            n_errors++;
            $display("FAIL fairness got n=%0d first=%0d breaks=%0d exp n=21 first=10 breaks=0",
                     obs_q.size(), obs_q[0], alt_bad);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int t = 1; t <= 4; t++) begin
            clear_drive();
            drive(1, t, $urandom, 4'b0, 0);
            n_checks++;
            if (out_ready[1] !== 1'b1) begin
                n_errors++;
                $display("FAIL refill_ready t=%0d got=%b exp=1", t, out_ready[1]);
            end
            tick();
        end
        idle(3);
        n_checks++;
        if (obs_q.size() != 4 || obs_q[0] !== 1 || obs_q[1] !== 2 || obs_q[2] !== 3 || obs_q[3] !== 4 ||
            obs_cyc[3] != obs_cyc[0] + 3) begin
            n_errors++;
            $display("FAIL refill_stream got n=%0d order=%p exp consecutive 1,2,3,4", obs_q.size(), obs_q);
        end
    endtask

    task automatic test_icc_err();
        do_reset();
        drive(2, 6, 32'hFFFF_FFFF, 4'b1001, 1);
        tick();
        clear_drive();
        tick();
        n_checks++;
        if (out_CDB_broadcast !== 1 || out_CDB_tag !== 6 || out_ICC_flags !== 4'b1001 || out_ICC_we !== 1) begin
            n_errors++;
            $display("FAIL icc got bc=%b tag=%0d icc=%b we=%b exp bc=1 tag=6 icc=1001 we=1",
                     out_CDB_broadcast, out_CDB_tag, out_ICC_flags, out_ICC_we);
        end
        tick();
        drive(2, INV, 32'h1234_5678, 4'b1111, 1);
        tick();
        idle(3);
        n_checks++;
        if (obs_q.size() != 1 || out_tag_err !== 1) begin
            n_errors++;
            $display("FAIL tag_err got strobes=%0d err=%b exp strobes=1 err=1", obs_q.size(), out_tag_err);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int t = 0; t < 300; t++) begin
            clear_drive();
            for (int s = 0; s < NUM; s++) begin
                if ($urandom_range(0, 99) < 60)
                    drive(s, $urandom_range(0, 31), $urandom, 4'($urandom), 1'($urandom));
            end
            tick();
        end
        idle(NUM + 1);
    endtask

    task automatic test_reset_midflight();
        do_reset();
        for (int s = 0; s < NUM; s++) drive(s, s + 1, $urandom, 4'($urandom), 1);
        tick();
        clear_drive();
        tick();
        n_checks++;
        if (out_CDB_broadcast !== 1) begin
            n_errors++;
            $display("FAIL midflight_pre got bc=%b exp 1", out_CDB_broadcast);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_CDB_broadcast !== 0 || out_ready !== 4'b1111 || out_ICC_we !== 0) begin
            n_errors++;
            $display("FAIL midflight_async got bc=%b ready=%b we=%b exp bc=0 ready=1111 we=0",
                     out_CDB_broadcast, out_ready, out_ICC_we);
        end
        #1;
        rst_n = 1'b1;
        model_reset();
        obs_q.delete();
        obs_cyc.delete();
        idle(5);
        n_checks++;
        if (obs_q.size() != 0 || out_ready !== 4'b1111) begin
            n_errors++;
            $display("FAIL midflight_after got strobes=%0d ready=%b exp strobes=0 ready=1111",
                     obs_q.size(), out_ready);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_three_way();
        test_fairness();
        test_back_to_back();
        test_icc_err();
        test_random();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
